// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - requester-side agent for a round-robin arbiter with command FIFO, timeout, retry and idle gap
module arb_requester #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 4,
    parameter int TIMEOUT    = 64,
    parameter int IDLE_GAP   = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cmd_valid_i,
    input  logic [LEN_W-1:0]              cmd_len_i,
    output logic                          cmd_ready_o,
    input  logic                          gnt_i,
    output logic                          req_o,
    output logic                          bus_active_o,
    output logic                          beat_o,
    output logic [LEN_W-1:0]              beat_idx_o,
    output logic [LEN_W-1:0]              cur_len_o,
    output logic                          done_o,
    output logic                          timeout_err_o,
    output logic                          preempt_o,
    output logic [$clog2(FIFO_DEPTH):0]   pending_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    localparam int GAP_W  = $clog2(IDLE_GAP) + 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(IDLE_GAP - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OWN  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t              state_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic [LEN_W-1:0]    beat_idx_q;
    logic                req_q;
    logic                active_q;
    logic                done_q;
    logic                tmo_q;
    logic                pre_q;

    logic [LEN_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic                push;
    logic                pop;
    logic [LEN_W-1:0]    head_len;

    assign cmd_ready_o = (count_q != CNT_FULL);
    assign push        = cmd_valid_i && cmd_ready_o;
    assign head_len    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

    assign req_o         = req_q;
    assign bus_active_o  = active_q;
    assign beat_o        = active_q && gnt_i;
    assign beat_idx_o    = beat_idx_q;
    assign cur_len_o     = head_len;
    assign done_o        = done_q;
    assign timeout_err_o = tmo_q;
    assign preempt_o     = pre_q;
    assign pending_o     = count_q;

    // Head command leaves the FIFO only when its burst completes or its grant wait expires.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            REQ:     pop = !gnt_i && (wait_cnt_q == WAIT_LAST);
            OWN:     pop = gnt_i && (beat_idx_q == head_len);
            default: pop = 1'b0;
        endcase
    end

    // Command storage; contents need no reset because count_q gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_len_i;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Ownership FSM with registered req/bus_active and single-cycle status pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            gap_cnt_q  <= '0;
            beat_idx_q <= '0;
            req_q      <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            pre_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
            pre_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q    <= REQ;
                        req_q      <= 1'b1;
                        wait_cnt_q <= '0;
                    end
                end
                REQ: begin
                    if (gnt_i) begin
                        // A grant arriving on the last allowed cycle still wins.
                        state_q    <= OWN;
                        active_q   <= 1'b1;
                        beat_idx_q <= '0;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q    <= GAP;
                        req_q      <= 1'b0;
                        tmo_q      <= 1'b1;
                        gap_cnt_q  <= '0;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                OWN: begin
                    if (gnt_i) begin
                        if (beat_idx_q == head_len) begin
                            state_q    <= GAP;
                            req_q      <= 1'b0;
                            active_q   <= 1'b0;
                            done_q     <= 1'b1;
                            gap_cnt_q  <= '0;
                            beat_idx_q <= '0;
                        end else begin
                            beat_idx_q <= beat_idx_q + LEN_W'(1);
                        end
                    end else begin
                        // Grant lost: keep the command, the retry restarts from beat 0.
                        state_q    <= GAP;
                        req_q      <= 1'b0;
                        active_q   <= 1'b0;
                        pre_q      <= 1'b1;
                        gap_cnt_q  <= '0;
                        beat_idx_q <= '0;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q   <= IDLE;
                        gap_cnt_q <= '0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_requester.sv
// tb/tb_arb_requester.sv - randomized and directed bench for arb_requester against a queue-based model
module tb_arb_requester;

    localparam int DEPTH = 4;
    localparam int LW    = 4;
    localparam int TMO   = 8;
    localparam int GAPC  = 1;

    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_OWN  = 2;
    localparam int M_GAP  = 3;

    logic          clk_i;
    logic          rst_i;
    logic          cmd_valid_i;
    logic [LW-1:0] cmd_len_i;
    logic          cmd_ready_o;
    logic          gnt_i;
    logic          req_o;
    logic          bus_active_o;
    logic          beat_o;
    logic [LW-1:0] beat_idx_o;
    logic [LW-1:0] cur_len_o;
    logic          done_o;
    logic          timeout_err_o;
    logic          preempt_o;
    logic [2:0]    pending_o;

    arb_requester #(
        .FIFO_DEPTH(DEPTH),
        .LEN_W     (LW),
        .TIMEOUT   (TMO),
        .IDLE_GAP  (GAPC)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_len_i    (cmd_len_i),
        .cmd_ready_o  (cmd_ready_o),
        .gnt_i        (gnt_i),
        .req_o        (req_o),
        .bus_active_o (bus_active_o),
        .beat_o       (beat_o),
        .beat_idx_o   (beat_idx_o),
        .cur_len_o    (cur_len_o),
        .done_o       (done_o),
        .timeout_err_o(timeout_err_o),
        .preempt_o    (preempt_o),
        .pending_o    (pending_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // observed event counters for directed tests
    int n_beat, n_done, n_tmo, n_pre, n_req;

    // reference model: command queue plus ownership phase and its counters
    int mq[$];
    int m_st, m_idx, m_wait, m_gap;
    bit m_done, m_tmo, m_pre;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clr_obs();
        n_beat = 0; n_done = 0; n_tmo = 0; n_pre = 0; n_req = 0;
    endtask

    // one clock cycle: drive, check against model, advance model, advance clock
    task automatic cyc(input bit r, input bit v, input int l, input bit g);
        int  n;
        bit  do_pop;
        bit  push_ok;
        bit  e_own;
        rst_i       = r;
        cmd_valid_i = v;
        cmd_len_i   = LW'(l);
        gnt_i       = g;
        #1;
        if (chk_on) begin
            e_own = (m_st == M_OWN);
            check_eq("req", req_o, (m_st == M_REQ) || e_own);
            check_eq("bus_active", bus_active_o, e_own);
            check_eq("beat", beat_o, e_own && g);
            check_eq("beat_idx", beat_idx_o, e_own ? m_idx : 0);
            check_eq("cur_len", cur_len_o, (mq.size() > 0) ? mq[0] : 0);
            check_eq("pending", pending_o, mq.size());
            check_eq("cmd_ready", cmd_ready_o, mq.size() < DEPTH);
            check_eq("done", done_o, m_done);
            check_eq("timeout_err", timeout_err_o, m_tmo);
            check_eq("preempt", preempt_o, m_pre);
            if (beat_o === 1'b1)        n_beat++;
            if (done_o === 1'b1)        n_done++;
            if (timeout_err_o === 1'b1) n_tmo++;
            if (preempt_o === 1'b1)     n_pre++;
            if (req_o === 1'b1)         n_req++;
        end
        if (!r) begin
            mq.delete();
            m_st = M_IDLE; m_idx = 0; m_wait = 0; m_gap = 0;
            m_done = 0; m_tmo = 0; m_pre = 0;
        end else begin
            n       = mq.size();
            do_pop  = 0;
            push_ok = v && (n < DEPTH);
            m_done = 0; m_tmo = 0; m_pre = 0;
            case (m_st)
                M_IDLE: if (n > 0) begin m_st = M_REQ; m_wait = 0; end
                M_REQ: begin
                    m_wait++;
                    if (g) begin
                        m_st = M_OWN; m_idx = 0;
                    end else if (m_wait == TMO) begin
                        m_st = M_GAP; m_gap = GAPC; do_pop = 1; m_tmo = 1;
                    end
                end
                M_OWN: begin
                    if (g) begin
                        if (m_idx == mq[0]) begin
                            do_pop = 1; m_done = 1; m_st = M_GAP; m_gap = GAPC; m_idx = 0;
                        end else begin
                            m_idx++;
                        end
                    end else begin
                        m_pre = 1; m_st = M_GAP; m_gap = GAPC; m_idx = 0;
                    end
                end
                default: begin
                    m_gap--;
                    if (m_gap == 0) m_st = M_IDLE;
                end
            endcase
            if (do_pop) void'(mq.pop_front());
            if (push_ok) mq.push_back(l);
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        int bias;
        rst_i = 1'b0; cmd_valid_i = 1'b0; cmd_len_i = '0; gnt_i = 1'b0;
        @(negedge clk_i);

        // T1 reset
        chk_on = 1'b0;
        cyc(0, 0, 0, 0);
        chk_on = 1'b1;
        cyc(0, 0, 0, 0);
        check_eq("t1_cmd_ready", cmd_ready_o, 1);
        check_eq("t1_pending", pending_o, 0);

        // T2 single burst len=2, grant one cycle after req
        clr_obs();
        cyc(1, 1, 2, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        check_eq("t2_beats", n_beat, 3);
        check_eq("t2_done", n_done, 1);
        check_eq("t2_pending", pending_o, 0);

        // T3 timeout with gnt held low
        clr_obs();
        cyc(1, 1, 5, 0);
        for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0);
        check_eq("t3_req_cycles", n_req, TMO);
        check_eq("t3_timeouts", n_tmo, 1);
        check_eq("t3_beats", n_beat, 0);
        check_eq("t3_pending", pending_o, 0);

        // T4 overfill: fifth push dropped, four bursts served in order
        clr_obs();
        for (int i = 1; i <= 5; i++) cyc(1, 1, i, 0);
        for (int i = 0; i < 40; i++) cyc(1, 0, 0, 1);
        check_eq("t4_beats", n_beat, 14);
        check_eq("t4_done", n_done, 4);
        check_eq("t4_tmo", n_tmo, 0);

        // T5 grant lost after beat 1, retried from beat 0
        clr_obs();
        cyc(1, 1, 3, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 1);
        check_eq("t5_preempt", n_pre, 1);
        check_eq("t5_beats", n_beat, 6);
        check_eq("t5_done", n_done, 1);

        // T6 reset during beat 2 of len=7 with two more queued
        clr_obs();
        cyc(1, 1, 7, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 1, 2, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        check_eq("t6_pending_before", pending_o, 3);
        cyc(0, 0, 0, 1);
        check_eq("t6_req", req_o, 0);
        check_eq("t6_pending", pending_o, 0);
        cyc(1, 0, 0, 1);
        check_eq("t6_done", n_done, 0);

        // randomized traffic with varying grant bias
        bias = 70;
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(0, 3))
                    0:       bias = 0;
                    1:       bias = 50;
                    2:       bias = 85;
                    default: bias = 100;
                endcase
            end
            cyc(($urandom_range(0, 299) != 0),
                ($urandom_range(0, 1) == 1),
                int'($urandom_range(0, 15)),
                ($urandom_range(0, 99) < bias));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
